// File: rtl/mcdt_pkg.sv
// Shared types and default constants for the multi-channel data transfer block.
package mcdt_pkg;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int NUM_CH_DEF = 3;
    localparam int DW_DEF     = 32;
    localparam int DEPTH_DEF  = 32;

    // Channel-id width; a single bit is still needed for two channels.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mcdt_fifo.sv
// Per-channel synchronous FIFO with registered ready and free-slot margin.
module mcdt_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int MW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o,
    output logic          ready_o,
    output logic [MW-1:0] margin_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [MW-1:0] wr_ptr_q, wr_ptr_d;
    logic [MW-1:0] rd_ptr_q, rd_ptr_d;
    logic [MW-1:0] margin_q, margin_d;
    logic [MW-1:0] count_s, count_d;
    logic          ready_q, ready_d;
    logic          push_s, pop_s, empty_s, full_s;

    // Pointer, occupancy and flag next-state; the extra pointer bit separates full from empty.
    always_comb begin
        count_s  = wr_ptr_q - rd_ptr_q;
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (count_s == MW'(DEPTH));
        push_s   = push_i & ready_q & ~full_s;
        pop_s    = pop_i & ~empty_s;
        wr_ptr_d = wr_ptr_q + MW'(push_s);
        rd_ptr_d = rd_ptr_q + MW'(pop_s);
        count_d  = count_s + MW'(push_s) - MW'(pop_s);
        ready_d  = (count_d != MW'(DEPTH));
        margin_d = MW'(DEPTH) - count_d;
    end

    // State registers; ready stays low while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            margin_q <= MW'(DEPTH);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            margin_q <= margin_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o  = empty_s;
    assign ready_o  = ready_q;
    assign margin_o = margin_q;

endmodule

// File: rtl/mcdt_n.sv
// N-channel FIFO concentrator: per-channel FIFOs, fixed or round-robin arbiter, and a stallable output register.
module mcdt_n
    import mcdt_pkg::*;
#(
    parameter  int        NUM_CH   = NUM_CH_DEF,
    parameter  int        DW       = DW_DEF,
    parameter  int        DEPTH    = DEPTH_DEF,
    parameter  arb_mode_e ARB_MODE = ARB_FIXED,
    localparam int        MW       = $clog2(DEPTH) + 1,
    localparam int        IDW      = id_width(NUM_CH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_CH*DW-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]    ch_valid_i,
    output logic [NUM_CH-1:0]    ch_ready_o,
    output logic [NUM_CH*MW-1:0] ch_margin_o,
    output logic [DW-1:0]        mcdt_data_o,
    output logic                 mcdt_val_o,
    output logic [IDW-1:0]       mcdt_id_o,
    input  logic                 mcdt_ready_i
);

    logic [NUM_CH-1:0]    pop_s, empty_s;
    logic [NUM_CH*DW-1:0] rdata_s;
    logic [DW-1:0]        sel_data_s, data_q, data_d;
    logic [IDW-1:0]       grant_s, cand_s, id_q, id_d, last_grant_q, last_grant_d;
    logic                 found_s, out_free_s, do_pop_s, val_q, val_d;
    int                   cand_int_s;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        mcdt_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .wdata_i  (ch_data_i[n*DW +: DW]),
            .push_i   (ch_valid_i[n]),
            .pop_i    (pop_s[n]),
            .rdata_o  (rdata_s[n*DW +: DW]),
            .empty_o  (empty_s[n]),
            .ready_o  (ch_ready_o[n]),
            .margin_o (ch_margin_o[n*MW +: MW])
        );
    end

    // Arbiter: first non-empty channel, scanning from 0 (fixed) or from last_grant+1 (round-robin).
    always_comb begin
        grant_s    = '0;
        found_s    = 1'b0;
        cand_int_s = 0;
        cand_s     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_int_s = (ARB_MODE == ARB_RR) ? (int'(last_grant_q) + 1 + i) : i;
            cand_int_s = (cand_int_s >= NUM_CH) ? (cand_int_s - NUM_CH) : cand_int_s;
            cand_s     = IDW'(cand_int_s);
            if (!found_s && !empty_s[cand_s]) begin
                found_s = 1'b1;
                grant_s = cand_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Read-data mux for the granted channel.
    always_comb begin
        sel_data_s = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (grant_s == IDW'(n)) begin
                sel_data_s = rdata_s[n*DW +: DW];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Output register next-state: load on pop, clear when drained, hold while stalled.
    always_comb begin
        out_free_s   = ~val_q | mcdt_ready_i;
        do_pop_s     = out_free_s & found_s;
        pop_s        = '0;
        data_d       = data_q;
        id_d         = id_q;
        val_d        = val_q;
        last_grant_d = last_grant_q;
        if (do_pop_s) begin
            pop_s[grant_s] = 1'b1;
            data_d         = sel_data_s;
            id_d           = grant_s;
            val_d          = 1'b1;
            last_grant_d   = grant_s;
        end else if (out_free_s) begin
            val_d = 1'b0;
        end else begin
            val_d = val_q;
        end
    end

    // Output and arbitration state; last_grant resets so the first round-robin grant is channel 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q       <= '0;
            id_q         <= '0;
            val_q        <= 1'b0;
            last_grant_q <= IDW'(NUM_CH - 1);
        end else begin
            data_q       <= data_d;
            id_q         <= id_d;
            val_q        <= val_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign mcdt_data_o = data_q;
    assign mcdt_id_o   = id_q;
    assign mcdt_val_o  = val_q;

endmodule

// File: tb/tb_mcdt_n.sv
// Bench for mcdt_n: a fixed-priority and a round-robin instance share stimulus; vector table plus scoreboarded scenarios.
module tb_mcdt_n;
    import mcdt_pkg::*;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int MW  = 6;
    localparam int IDW = 2;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [NCH*DW-1:0]  ch_data_i;
    logic [NCH-1:0]     ch_valid_i;
    logic               mcdt_ready_i;
    logic [NCH-1:0]     ch_ready_o, rr_ready;
    logic [NCH*MW-1:0]  ch_margin_o, rr_margin;
    logic [DW-1:0]      mcdt_data_o, rr_data;
    logic               mcdt_val_o, rr_val;
    logic [IDW-1:0]     mcdt_id_o, rr_id;

    mcdt_n #(.NUM_CH(NCH), .DW(DW), .DEPTH(32), .ARB_MODE(ARB_FIXED)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .ch_data_i(ch_data_i), .ch_valid_i(ch_valid_i),
        .ch_ready_o(ch_ready_o), .ch_margin_o(ch_margin_o), .mcdt_data_o(mcdt_data_o),
        .mcdt_val_o(mcdt_val_o), .mcdt_id_o(mcdt_id_o), .mcdt_ready_i(mcdt_ready_i)
    );

    mcdt_n #(.NUM_CH(NCH), .DW(DW), .DEPTH(32), .ARB_MODE(ARB_RR)) u_dut_rr (
        .clk_i(clk_i), .rst_i(rst_i), .ch_data_i(ch_data_i), .ch_valid_i(ch_valid_i),
        .ch_ready_o(rr_ready), .ch_margin_o(rr_margin), .mcdt_data_o(rr_data),
        .mcdt_val_o(rr_val), .mcdt_id_o(rr_id), .mcdt_ready_i(mcdt_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    typedef struct { logic [1:0] id; logic [31:0] data; } obs_t;
    typedef struct {
        logic rst; logic [2:0] valid; logic rdy;
        logic val; logic [1:0] id; logic [31:0] data; logic [2:0] ready;
        logic [5:0] m0; logic [5:0] m1; logic [5:0] m2;
    } vec_t;

    exp_t q0[$], q1[$], q2[$];
    obs_t obs_fix[$], obs_rr[$];
    vec_t tbl[13];
    int   n_vec = 0, n_err = 0;
    bit   mon_en = 1'b0, rec_en = 1'b0, prev_stall = 1'b0;
    logic [31:0] pdata;
    logic [1:0]  pid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int c);
        case (c)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return 0;
        endcase
    endfunction

    function automatic int pending();
        return q0.size() + q1.size() + q2.size();
    endfunction

    task automatic push_exp(input int c, input logic [31:0] d, input int cy);
        exp_t e;
        e.data = d;
        e.cyc  = cy;
        case (c)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic exp_t pop_q(input int c);
        case (c)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic set_ch(input int c, input logic [31:0] d);
        ch_data_i[c*DW +: DW] = d;
    endtask

    task automatic clear_sb();
        q0.delete(); q1.delete(); q2.delete();
        prev_stall = 1'b0;
    endtask

    // Called at the falling edge: the transfer decision for the coming rising edge is visible here.
    task automatic monitor();
        exp_t e;
        obs_t o;
        if (mon_en && !rst_i) begin
            if (prev_stall) begin
                chk("hold_val", 64'(mcdt_val_o), 64'd1);
                chk("hold_data", 64'(mcdt_data_o), 64'(pdata));
                chk("hold_id", 64'(mcdt_id_o), 64'(pid));
            end
            if (mcdt_val_o && mcdt_ready_i) begin
                if (rec_en) begin
                    o.id = mcdt_id_o; o.data = mcdt_data_o;
                    obs_fix.push_back(o);
                end
                if (qsize(int'(mcdt_id_o)) == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_out: got id %0d data %h, expected no output", mcdt_id_o, mcdt_data_o);
                end else begin
                    e = pop_q(int'(mcdt_id_o));
                    chk("out_data", 64'(mcdt_data_o), 64'(e.data));
                    if (e.cyc != 0) chk("out_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_stall = mcdt_val_o && !mcdt_ready_i;
            pdata = mcdt_data_o;
            pid   = mcdt_id_o;
            if (rec_en && rr_val && mcdt_ready_i) begin
                o.id = rr_id; o.data = rr_data;
                obs_rr.push_back(o);
            end
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0; rec_en = 1'b0;
        rst_i = 1'b1; ch_valid_i = '0; mcdt_ready_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        clear_sb();
    endtask

    task automatic drain(input string name, input int budget, input bit toggle);
        for (int t = 0; t < budget && pending() > 0; t++) begin
            if (toggle) mcdt_ready_i = ~mcdt_ready_i;
            step();
        end
        mcdt_ready_i = 1'b1;
        repeat (3) step();
        chk({name, "_left"}, 64'(pending()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] v;
        int seqn[3];
        logic [31:0] d;

        tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 32'h0,         3'b000, 6'd32, 6'd32, 6'd32};
        tbl[1]  = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 32'h0,         3'b111, 6'd32, 6'd32, 6'd32};
        tbl[2]  = '{1'b0, 3'b001, 1'b0, 1'b0, 2'd0, 32'h0,         3'b111, 6'd31, 6'd32, 6'd32};
        tbl[3]  = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 32'hAAAA_0000, 3'b111, 6'd32, 6'd32, 6'd32};
        tbl[4]  = '{1'b0, 3'b010, 1'b0, 1'b1, 2'd0, 32'hAAAA_0000, 3'b111, 6'd32, 6'd31, 6'd32};
        tbl[5]  = '{1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 32'hAAAA_0001, 3'b111, 6'd32, 6'd32, 6'd32};
        tbl[6]  = '{1'b0, 3'b000, 1'b1, 1'b0, 2'd1, 32'hAAAA_0001, 3'b111, 6'd32, 6'd32, 6'd32};
        tbl[7]  = '{1'b0, 3'b111, 1'b1, 1'b0, 2'd1, 32'hAAAA_0001, 3'b111, 6'd31, 6'd31, 6'd31};
        tbl[8]  = '{1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 32'hAAAA_0000, 3'b111, 6'd32, 6'd31, 6'd31};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 32'hAAAA_0000, 3'b111, 6'd32, 6'd31, 6'd31};
        tbl[10] = '{1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 32'hAAAA_0001, 3'b111, 6'd32, 6'd32, 6'd31};
        tbl[11] = '{1'b0, 3'b000, 1'b1, 1'b1, 2'd2, 32'hAAAA_0002, 3'b111, 6'd32, 6'd32, 6'd32};
        tbl[12] = '{1'b0, 3'b000, 1'b1, 1'b0, 2'd2, 32'hAAAA_0002, 3'b111, 6'd32, 6'd32, 6'd32};

        rst_i = 1'b1; ch_valid_i = '0; mcdt_ready_i = 1'b0;
        ch_data_i = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
        #3;
        chk("rst_val", 64'(mcdt_val_o), 64'd0);
        chk("rst_data", 64'(mcdt_data_o), 64'd0);
        chk("rst_id", 64'(mcdt_id_o), 64'd0);
        chk("rst_ready", 64'(ch_ready_o), 64'd0);
        chk("rst_margin", 64'(ch_margin_o), 64'({6'd32, 6'd32, 6'd32}));
        chk("rst_rr_val", 64'(rr_val), 64'd0);

        // Cycle-by-cycle vector table.
        for (int r = 0; r < 13; r++) begin
            rst_i = tbl[r].rst; ch_valid_i = tbl[r].valid; mcdt_ready_i = tbl[r].rdy;
            @(posedge clk_i);
            #1;
            chk($sformatf("tbl%0d_val", r), 64'(mcdt_val_o), 64'(tbl[r].val));
            chk($sformatf("tbl%0d_id", r), 64'(mcdt_id_o), 64'(tbl[r].id));
            chk($sformatf("tbl%0d_data", r), 64'(mcdt_data_o), 64'(tbl[r].data));
            chk($sformatf("tbl%0d_ready", r), 64'(ch_ready_o), 64'(tbl[r].ready));
            chk($sformatf("tbl%0d_margin", r), 64'(ch_margin_o), 64'({tbl[r].m2, tbl[r].m1, tbl[r].m0}));
        end

        // Back-to-back bursts of 10 per channel with downstream always ready.
        do_reset();
        mon_en = 1'b1; mcdt_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 10; i++) begin
                d = 32'h00C0_0000 + (32'(c) << 16) + 32'(i);
                set_ch(c, d);
                ch_valid_i = 3'(1 << c);
                push_exp(c, d, cyc + 2);
                step();
            end
        end
        ch_valid_i = '0;
        drain("s1", 40, 1'b0);

        // Fill channel 0 behind a stalled output register holding a channel 1 word.
        do_reset();
        mon_en = 1'b1; mcdt_ready_i = 1'b0;
        set_ch(1, 32'h00B1_0000); ch_valid_i = 3'b010; push_exp(1, 32'h00B1_0000, 0);
        step();
        ch_valid_i = '0;
        step();
        chk("s2_margin_start", 64'(ch_margin_o[5:0]), 64'd32);
        for (int k = 1; k <= 32; k++) begin
            d = 32'h00B0_0000 + 32'(k - 1);
            set_ch(0, d); ch_valid_i = 3'b001; push_exp(0, d, 0);
            step();
            chk("s2_margin", 64'(ch_margin_o[5:0]), 64'(32 - k));
            chk("s2_ready0", 64'(ch_ready_o[0]), 64'(k < 32));
        end
        set_ch(0, 32'h00B0_00FF); ch_valid_i = 3'b001;
        step();
        ch_valid_i = '0;
        chk("s2_drop_margin", 64'(ch_margin_o[5:0]), 64'd0);
        chk("s2_drop_ready", 64'(ch_ready_o[0]), 64'd0);
        mcdt_ready_i = 1'b1;
        drain("s2", 60, 1'b0);

        // Preload 4 words per channel and compare fixed vs round-robin id order.
        do_reset();
        mon_en = 1'b1; rec_en = 1'b1; obs_fix.delete(); obs_rr.delete();
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 3; c++) begin
                d = 32'h00D0_0000 + (32'(c) << 16) + 32'(w);
                set_ch(c, d); push_exp(c, d, 0);
            end
            ch_valid_i = 3'b111;
            step();
        end
        ch_valid_i = '0; mcdt_ready_i = 1'b1;
        drain("s3", 40, 1'b0);
        rec_en = 1'b0;
        chk("s3_fix_count", 64'(obs_fix.size()), 64'd12);
        chk("s3_rr_count", 64'(obs_rr.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < obs_fix.size()) chk($sformatf("s3_fix_id%0d", i), 64'(obs_fix[i].id), 64'(i / 4));
            if (i < obs_rr.size()) begin
                chk($sformatf("s3_rr_id%0d", i), 64'(obs_rr[i].id), 64'(i % 3));
                chk($sformatf("s3_rr_data%0d", i), 64'(obs_rr[i].data),
                    64'(32'h00D0_0000 + (32'(i % 3) << 16) + 32'(i / 3)));
            end
        end

        // Random writes while downstream ready toggles every cycle.
        do_reset();
        mon_en = 1'b1; mcdt_ready_i = 1'b0;
        seqn = '{0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            v = 3'($urandom_range(1, 7));
            for (int c = 0; c < 3; c++) begin
                if (v[c]) begin
                    d = 32'h00E0_0000 + (32'(c) << 16) + 32'(seqn[c]);
                    set_ch(c, d); push_exp(c, d, 0);
                    seqn[c]++;
                end
            end
            ch_valid_i = v;
            mcdt_ready_i = ~mcdt_ready_i;
            step();
        end
        ch_valid_i = '0;
        drain("s4", 100, 1'b1);

        // Asynchronous reset with five words buffered.
        do_reset();
        mon_en = 1'b1; mcdt_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 32'h00F0_0000 + ((i < 3) ? 32'h0 : 32'h0001_0000) + 32'(i);
            set_ch((i < 3) ? 0 : 1, d);
            ch_valid_i = (i < 3) ? 3'b001 : 3'b010;
            push_exp((i < 3) ? 0 : 1, d, 0);
            step();
        end
        ch_valid_i = '0;
        chk("s5_val_before", 64'(mcdt_val_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("s5_rst_val", 64'(mcdt_val_o), 64'd0);
        chk("s5_rst_data", 64'(mcdt_data_o), 64'd0);
        chk("s5_rst_ready", 64'(ch_ready_o), 64'd0);
        chk("s5_rst_margin", 64'(ch_margin_o), 64'({6'd32, 6'd32, 6'd32}));
        chk("s5_rst_rr_val", 64'(rr_val), 64'd0);
        clear_sb();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step();
        chk("s5_ready_after", 64'(ch_ready_o), 64'b111);
        chk("s5_margin_after", 64'(ch_margin_o), 64'({6'd32, 6'd32, 6'd32}));
        mcdt_ready_i = 1'b1;
        repeat (6) step();
        set_ch(2, 32'h00F2_0099); ch_valid_i = 3'b100; push_exp(2, 32'h00F2_0099, cyc + 2);
        step();
        ch_valid_i = '0;
        drain("s5", 10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mcdt_n.md
MCDT_N -- requirements
Module: mcdt_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of input channels, legal range 2..8.
REQ-002 SHALL have parameter DW, default 32: data width per channel.
REQ-003 SHALL have parameter DEPTH, default 32: per-channel FIFO depth, power of two, range 4..256.
REQ-004 SHALL have parameter ARB_MODE, default ARB_FIXED: arbitration mode, either ARB_FIXED or ARB_RR.
REQ-005 SHALL define derived widths MW = $clog2(DEPTH)+1 and IDW = max(1, $clog2(NUM_CH)).
REQ-006 SHALL have ports as follows (one clock; reset is asynchronous and active-high):
  clk_i         in   1          clock; all logic is rising-edge.
  rst_i         in   1          asynchronous active-high reset.
  ch_data_i     in   NUM_CH*DW  channel n data in slice [n*DW +: DW].
  ch_valid_i    in   NUM_CH     per-channel write request.
  ch_ready_o    out  NUM_CH     per-channel FIFO not full.
  ch_margin_o   out  NUM_CH*MW  per-channel free slots, slice [n*MW +: MW].
  mcdt_data_o   out  DW         output data.
  mcdt_val_o    out  1          output data valid.
  mcdt_id_o     out  IDW        source channel of mcdt_data_o.
  mcdt_ready_i  in   1          downstream accept (new in this generation).

Function
REQ-007 SHALL accept a channel word on any rising edge where ch_valid_i[n] and ch_ready_o[n] are both 1; while ch_ready_o[n] is 0, ch_valid_i[n] SHALL be ignored (no write, no error).
REQ-008 SHALL drive ch_ready_o[n] = 1 if and only if FIFO n holds fewer than DEPTH words and reset is inactive.
REQ-009 SHALL drive ch_margin_o[n] = DEPTH minus FIFO n occupancy, registered, covering the range 0..DEPTH.
REQ-010 SHALL load the output register when it is free (mcdt_val_o==0, or mcdt_val_o==1 with mcdt_ready_i==1), with one word popped from the granted non-empty FIFO.
REQ-011 SHALL hold mcdt_data_o, mcdt_id_o and mcdt_val_o stable while mcdt_val_o==1 and mcdt_ready_i==0.
REQ-012 SHALL clear mcdt_val_o after a transfer when no FIFO is non-empty.
REQ-013 SHALL have a latency of 1 cycle: a word accepted at edge T into an empty FIFO with a free output register SHALL appear with mcdt_val_o=1 after edge T+1.
REQ-014 SHALL sustain one output word per cycle while mcdt_ready_i is 1 and any FIFO is non-empty.
REQ-015 SHALL, in ARB_FIXED mode, grant the lowest-index non-empty channel.
REQ-016 SHALL, in ARB_RR mode, search from last_grant+1 with wrap-around at NUM_CH-1 to 0, and SHALL update last_grant only on an actual pop.
REQ-017 SHALL allow a simultaneous push and pop on the same FIFO; occupancy is unchanged and margin_o stays constant.
REQ-018 SHALL not change ch_ready_o on a push into a full FIFO that coincides with a pop, since ready_o is already 0 at full (no bypass path).
REQ-019 SHALL wrap read and write pointers modulo DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-020 SHALL preserve per-channel order; no ordering between channels is guaranteed beyond the arbitration rule.

Reset
REQ-021 SHALL, while rst_i==1 (asynchronously), force mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0, ch_ready_o=0, ch_margin_o[n]=DEPTH, all FIFOs empty and last_grant=NUM_CH-1, so that the first RR grant goes to channel 0.
REQ-022 SHALL discard all buffered words, including the output register, on reset mid-operation; the first edge after deassertion SHALL set ch_ready_o to all ones.

Structure
REQ-023 SHALL place the arb_mode_e enum (ARB_FIXED, ARB_RR) and default parameter constants in package mcdt_pkg.
REQ-024 SHALL instantiate NUM_CH copies of a single sub-module mcdt_fifo (synchronous FIFO with push/pop/full/empty/margin), with arbiter and output register in mcdt_n.

Verification
REQ-025 SHALL cover: NUM_CH=3, DEPTH=32, mcdt_ready_i=1; 10 writes per channel, back-to-back (0x00C0_0000..0009, then C1, then C2) -> 30 outputs in order, with mcdt_id_o of 0, 1 and 2 respectively and each output 1 cycle after acceptance.
REQ-026 SHALL cover: mcdt_ready_i=0 and 32 writes to ch0 -> ch0_margin counts 32..0, ready_o=0 after the 32nd write, and a 33rd valid is dropped; release ready -> 32 words out.
REQ-027 SHALL cover: ARB_FIXED with all three FIFOs preloaded with 4 words -> id sequence 0,0,0,0,1,1,1,1,2,2,2,2.
REQ-028 SHALL cover: ARB_RR with the same preload -> id sequence 0,1,2,0,1,2,0,1,2,0,1,2.
REQ-029 SHALL cover: mcdt_ready_i toggled every cycle -> data/id held while stalled, with no loss or duplication.
REQ-030 SHALL cover: rst_i pulsed mid-stream with 5 words buffered -> val_o=0 immediately, margins=DEPTH, and no stale words after reset.
